// File: rtl/rsr_multilat_scheduler_pkg.sv
// Shared types and defaults for the multi-latency wakeup-tag delay scheduler.
// Tag width defaults to the physical register tag width of the codebase.
package rsr_multilat_scheduler_pkg;

  localparam int PHYS_W_DEFAULT = 7;

  localparam int MAX_LATENCY_DEFAULT = 4;
  localparam int LAT_W_DEFAULT       = $clog2(MAX_LATENCY_DEFAULT + 1);

  typedef logic [LAT_W_DEFAULT-1:0] rsr_lat_t;

  typedef struct packed {
    logic [PHYS_W_DEFAULT-1:0] tag;
    logic                      valid;
  } rsr_lane_t;

  // Latency L in 1..max_lat maps to slot L-1; anything else yields all zeros.
  function automatic logic [31:0] lat_to_slot(input int lat, input int max_lat);
    logic [31:0] onehot;
    onehot = '0;
    if (lat >= 1 && lat <= max_lat) onehot = 32'd1 << (lat - 1);
    return onehot;
  endfunction

endpackage

// File: rtl/rsr_multilat_lane.sv
// One issue lane: tag delay shift register, per-latency busy mask and drop detect.
// RSR_COLLISION_CHECK_EN adds the collision_o pulse port.
module rsr_multilat_lane
  import rsr_multilat_scheduler_pkg::*;
#(
  parameter int MAX_LATENCY = MAX_LATENCY_DEFAULT,
  parameter int PHYS_W      = PHYS_W_DEFAULT,
  parameter int LAT_W       = $clog2(MAX_LATENCY + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush_i,
  input  logic                   grantValid_i,
  input  logic [PHYS_W-1:0]      grantTag_i,
  input  logic [LAT_W-1:0]       grantLat_i,
  output logic [MAX_LATENCY-1:0] slotBusy_o,
  output logic                   rsrValid_o,
`ifdef RSR_COLLISION_CHECK_EN
  output logic                   collision_o,
`endif
  output logic [PHYS_W-1:0]      rsrTag_o
);

  logic [MAX_LATENCY-1:0] valid_reg, valid_next;
  logic [PHYS_W-1:0]      tag_reg  [MAX_LATENCY];
  logic [PHYS_W-1:0]      tag_next [MAX_LATENCY];

  // Extended views with an always-empty entry above the top slot feed the shift.
  logic [MAX_LATENCY:0]   valid_ext;
  logic [PHYS_W-1:0]      tag_ext  [MAX_LATENCY+1];

  logic [31:0]            slot_onehot;
  logic [MAX_LATENCY-1:0] slot_sel;
  logic [MAX_LATENCY-1:0] busy;
  logic                   lat_legal;
  logic                   slot_taken;
  logic                   grant_ok;

  assign valid_ext              = {1'b0, valid_reg};
  assign tag_ext[MAX_LATENCY]   = '0;

  assign slot_onehot = lat_to_slot(int'(grantLat_i), MAX_LATENCY);
  assign slot_sel    = slot_onehot[MAX_LATENCY-1:0];
  assign lat_legal   = |slot_onehot;

  // Latency L lands in slot L-1, which next cycle receives whatever sits in slot L now.
  assign busy       = valid_ext[MAX_LATENCY:1];
  assign slot_taken = |(slot_sel & busy);
  assign grant_ok   = grantValid_i & lat_legal & ~slot_taken & ~flush_i;

  genvar gi;
  generate
    for (gi = 0; gi < MAX_LATENCY; gi++) begin : g_slot
      assign tag_ext[gi] = tag_reg[gi];

      always_comb begin
        valid_next[gi] = 1'b0;
        tag_next[gi]   = tag_ext[gi+1];
        if (grant_ok && slot_sel[gi]) begin
          valid_next[gi] = 1'b1;
          tag_next[gi]   = grantTag_i;
        end else if (!flush_i) begin
          valid_next[gi] = valid_ext[gi+1];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_reg <= '0;
      for (int k = 0; k < MAX_LATENCY; k++) tag_reg[k] <= '0;
    end else begin
      valid_reg <= valid_next;
      for (int k = 0; k < MAX_LATENCY; k++) tag_reg[k] <= tag_next[k];
    end
  end

  assign slotBusy_o = busy;
  assign rsrValid_o = valid_reg[0];
  assign rsrTag_o   = tag_reg[0];

`ifdef RSR_COLLISION_CHECK_EN
  // A grant lost under flush is a recovery squash, not an error.
  assign collision_o = grantValid_i & ~flush_i & (~lat_legal | slot_taken);
`endif

endmodule

// File: rtl/rsr_multilat_scheduler.sv
// NUM_LANES independent wakeup-tag delay lanes with a sticky error flag.
// RSR_COLLISION_CHECK_EN enables collision_o and its assertion; otherwise collision_o is 0.
module rsr_multilat_scheduler
  import rsr_multilat_scheduler_pkg::*;
#(
  parameter int NUM_LANES   = 4,
  parameter int MAX_LATENCY = MAX_LATENCY_DEFAULT,
  parameter int PHYS_W      = PHYS_W_DEFAULT,
  parameter int LAT_W       = $clog2(MAX_LATENCY + 1)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             flush_i,
  input  logic [NUM_LANES-1:0]             grantValid_i,
  input  logic [NUM_LANES*PHYS_W-1:0]      grantTag_i,
  input  logic [NUM_LANES*LAT_W-1:0]       grantLat_i,
  output logic [NUM_LANES*MAX_LATENCY-1:0] slotBusy_o,
  output logic [NUM_LANES-1:0]             rsrValid_o,
  output logic [NUM_LANES*PHYS_W-1:0]      rsrTag_o,
  output logic                             collision_o
);

`ifdef RSR_COLLISION_CHECK_EN
  logic [NUM_LANES-1:0] collision_pulse;
  logic                 collision_reg;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      rsr_multilat_lane #(
        .MAX_LATENCY (MAX_LATENCY),
        .PHYS_W      (PHYS_W),
        .LAT_W       (LAT_W)
      ) u_lane (
        .clk          (clk),
        .reset        (reset),
        .flush_i      (flush_i),
        .grantValid_i (grantValid_i[gi]),
        .grantTag_i   (grantTag_i[gi*PHYS_W +: PHYS_W]),
        .grantLat_i   (grantLat_i[gi*LAT_W +: LAT_W]),
        .slotBusy_o   (slotBusy_o[gi*MAX_LATENCY +: MAX_LATENCY]),
        .rsrValid_o   (rsrValid_o[gi]),
`ifdef RSR_COLLISION_CHECK_EN
        .collision_o  (collision_pulse[gi]),
`endif
        .rsrTag_o     (rsrTag_o[gi*PHYS_W +: PHYS_W])
      );
    end
  endgenerate

`ifdef RSR_COLLISION_CHECK_EN
  // Only reset clears the flag so a recovery flush cannot hide a select-logic bug.
  always_ff @(posedge clk) begin
    if (reset) collision_reg <= 1'b0;
    else       collision_reg <= collision_reg | (|collision_pulse);
  end

  assign collision_o = collision_reg;

  a_no_collision : assert property (@(posedge clk) disable iff (reset) !(|collision_pulse))
    else $error("rsr_multilat_scheduler: grant dropped on collision or illegal latency");
`else
  assign collision_o = 1'b0;
`endif

endmodule

// File: tb/tb_rsr_multilat_scheduler.sv
// Scoreboard bench: each expected broadcast (cycle, lane, tag) is queued at grant time.
module tb_rsr_multilat_scheduler;
  import rsr_multilat_scheduler_pkg::*;

  localparam int NL = 4;
  localparam int ML = 4;
  localparam int PW = PHYS_W_DEFAULT;
  localparam int LW = $clog2(ML + 1);
`ifdef RSR_COLLISION_CHECK_EN
  localparam logic EXP_COL = 1'b1;
`else
  localparam logic EXP_COL = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                reset;
  logic                flush_i;
  logic [NL-1:0]       grantValid_i;
  logic [NL*PW-1:0]    grantTag_i;
  logic [NL*LW-1:0]    grantLat_i;
  logic [NL*ML-1:0]    slotBusy_o;
  logic [NL-1:0]       rsrValid_o;
  logic [NL*PW-1:0]    rsrTag_o;
  logic                collision_o;

  typedef struct {
    int cyc;
    int lane;
    int tag;
  } exp_t;

  exp_t sb[$];
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_pass   = 0;

  rsr_multilat_scheduler #(
    .NUM_LANES   (NL),
    .MAX_LATENCY (ML),
    .PHYS_W      (PW),
    .LAT_W       (LW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .flush_i      (flush_i),
    .grantValid_i (grantValid_i),
    .grantTag_i   (grantTag_i),
    .grantLat_i   (grantLat_i),
    .slotBusy_o   (slotBusy_o),
    .rsrValid_o   (rsrValid_o),
    .rsrTag_o     (rsrTag_o),
    .collision_o  (collision_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, got, exp);
  endtask

  // Drive one grant for the current cycle; legal ones are expected at cycle+lat.
  task automatic grant(input int lane, input int tag, input int lat, input bit expect_bcast);
    grantValid_i[lane]           = 1'b1;
    grantTag_i[lane*PW +: PW]    = PW'(tag);
    grantLat_i[lane*LW +: LW]    = LW'(lat);
    $display("cycle %0d: grant lane %0d tag %0d lat %0d%s", cyc, lane, tag, lat,
             expect_bcast ? "" : " (expected dropped)");
    if (expect_bcast) sb.push_back('{cyc: cyc + lat, lane: lane, tag: tag});
  endtask

  // Advance one clock, then compare broadcasts against everything due this cycle.
  task automatic step();
    logic [NL-1:0] exp_v;
    @(posedge clk);
    #1;
    cyc++;
    grantValid_i = '0;
    flush_i      = 1'b0;
    exp_v        = '0;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        exp_v[sb[i].lane] = 1'b1;
        check($sformatf("tag_lane%0d", sb[i].lane),
              64'(rsrTag_o[sb[i].lane*PW +: PW]), 64'(sb[i].tag));
        $display("cycle %0d: broadcast lane %0d tag %0d expected", cyc, sb[i].lane, sb[i].tag);
        sb.delete(i);
      end
    end
    check("valid", 64'(rsrValid_o), 64'(exp_v));
  endtask

  initial begin
    reset        = 1'b1;
    flush_i      = 1'b0;
    grantValid_i = '0;
    grantTag_i   = '0;
    grantLat_i   = '0;
    step();
    step();
    reset = 1'b0;
    check("reset_tag", 64'(rsrTag_o), 64'd0);
    check("reset_busy", 64'(slotBusy_o), 64'd0);
    check("reset_col", 64'(collision_o), 64'd0);

    // Latency sweep on lane 0: broadcasts at t+1, t+4, t+6.
    grant(0, 5, 1, 1'b1);
    step();
    grant(0, 6, 3, 1'b1);
    step();
    grant(0, 7, 4, 1'b1);
    step();
    repeat (5) step();

    // Busy mask walks down as lane 1's lat-4 tag advances; a lat-1 grant merges in.
    grant(1, 9, 4, 1'b1);
    step();
    check("busy_t1", 64'(slotBusy_o[1*ML +: ML]), 64'b0100);
    grant(1, 10, 1, 1'b1);
    step();
    check("busy_t2", 64'(slotBusy_o[1*ML +: ML]), 64'b0010);
    step();
    check("busy_t3", 64'(slotBusy_o[1*ML +: ML]), 64'b0001);
    repeat (3) step();

    // Collision on lane 2: older tag 3 survives, tag 4 is dropped.
    check("col_before", 64'(collision_o), 64'd0);
    grant(2, 3, 3, 1'b1);
    step();
    grant(2, 4, 2, 1'b0);
    step();
    check("col_after", 64'(collision_o), 64'(EXP_COL));
    repeat (4) step();

    // Illegal latencies on lane 3 never broadcast.
    grant(3, 11, 0, 1'b0);
    step();
    grant(3, 12, 5, 1'b0);
    step();
    repeat (5) step();
    check("col_illegal", 64'(collision_o), 64'(EXP_COL));

    // Flush with a simultaneous grant squashes everything in flight.
    for (int l = 0; l < NL; l++) grant(l, 20 + l, 4, 1'b1);
    step();
    flush_i = 1'b1;
    grant(0, 30, 2, 1'b0);
    sb.delete();
    $display("cycle %0d: flush", cyc);
    step();
    check("flush_busy", 64'(slotBusy_o), 64'd0);
    repeat (ML + 1) step();
    check("flush_col", 64'(collision_o), 64'(EXP_COL));

    // Reset mid-flight, together with flush and a grant, clears all outputs.
    grant(0, 1, 3, 1'b1);
    grant(1, 2, 4, 1'b1);
    step();
    grant(0, 3, 2, 1'b0);
    step();
    reset   = 1'b1;
    flush_i = 1'b1;
    grant(3, 4, 1, 1'b0);
    sb.delete();
    $display("cycle %0d: reset", cyc);
    step();
    reset = 1'b0;
    check("rst_tag", 64'(rsrTag_o), 64'd0);
    check("rst_busy", 64'(slotBusy_o), 64'd0);
    check("rst_col", 64'(collision_o), 64'd0);
    grant(2, 15, 2, 1'b1);
    step();
    check("post_rst_busy", 64'(slotBusy_o[2*ML +: ML]), 64'b0001);
    repeat (4) step();

    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rsr_multilat_scheduler.md
Name: rsr_multilat_scheduler

Overview:
- Multi-lane, variable-latency wakeup-tag delay scheduler for the issue stage.
- Per lane: a shift register of depth MAX_LATENCY. A granted instruction deposits its destination tag at the slot matching its execute latency (1..MAX_LATENCY). The tag is broadcast for wakeup when it reaches the head.
- Generalises the fixed simple/complex lane scheme: any mix of latencies per lane, NUM_LANES lanes, per-slot busy mask to select logic, and flush support.
- Loads with indeterminate latency do not use this block.

Parameters:
- NUM_LANES, 4, number of issue lanes (independent shift registers).
- MAX_LATENCY, 4, deepest supported execute latency in cycles; must be >= 1.
- PHYS_W, `SIZE_PHYSICAL_LOG, physical register tag width.
- LAT_W, $clog2(MAX_LATENCY+1), width of the latency field.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- flush_i  in  1  squash all in-flight tags (recovery).
- grantValid_i  in  NUM_LANES  lane n issued a tag-producing instruction this cycle.
- grantTag_i  in  NUM_LANES*PHYS_W  destination tag per lane.
- grantLat_i  in  NUM_LANES*LAT_W  execute latency per lane.
- slotBusy_o  out  NUM_LANES*MAX_LATENCY  bit [n*MAX_LATENCY+L-1] = 1 means latency L is unavailable on lane n this cycle.
- rsrValid_o  out  NUM_LANES  broadcast-tag valid per lane.
- rsrTag_o  out  NUM_LANES*PHYS_W  broadcast tag per lane.
- collision_o  out  1  sticky error flag (optional feature only).

Behaviour:
- State per lane: TAG[0..MAX_LATENCY-1] and VALID[0..MAX_LATENCY-1]. rsrValid_o/rsrTag_o = VALID[0]/TAG[0], driven straight from registers.
- Each clock, not in reset and not flushed:
  - Shift: entry k moves to k-1 for k >= 1.
  - Entry 0 retires.
  - Index MAX_LATENCY-1 becomes invalid unless written by a grant.
- Grant with latency L (1 <= L <= MAX_LATENCY) writes TAG[L-1] and sets VALID[L-1] at the same edge.
  - Issued in cycle t, the tag is broadcast during cycle t+L.
- slotBusy_o for latency L = VALID[L] for L < MAX_LATENCY; 0 for L = MAX_LATENCY. Purely combinational from state.
  - Select logic must not grant latency L on a lane where the bit is set.
- Collision (grant of L while VALID[L] = 1): the older entry wins, the new grant is dropped, and the tag is never broadcast.
- Illegal latency (0 or > MAX_LATENCY): grant dropped, no state change beyond the normal shift.
- flush_i = 1: all VALID cleared at the edge; any same-cycle grant is dropped. TAG contents are don't-care.
- reset: all VALID and TAG cleared. Reset dominates flush and grants, including mid-flight tags.
- Reset values: rsrValid_o = 0, rsrTag_o = 0, slotBusy_o = 0, collision_o = 0.
- Lanes are fully independent; identical tags on two lanes are legal and both are broadcast.
- grantTag_i is don't-care when grantValid_i = 0.

Optional Feature:
- Macro: RSR_COLLISION_CHECK_EN.
- Defined:
  - collision_o goes high one cycle after any collision or illegal-latency grant on any lane.
  - It stays high until reset; flush does not clear it.
  - A simulation assertion fires on the same event.
- Undefined: collision_o is tied to 0, no detection logic, no assertion. Drop behaviour is unchanged.

Decomposition:
- Shared package: rsr_lane_t (tag, valid struct), latency field type, MAX_LATENCY/LAT_W defaults, and a function mapping a latency to a one-hot slot index.
- One sub-module, rsr_multilat_lane: a single lane's shift register, busy mask and collision detect. It is instantiated NUM_LANES times in a generate loop. The top level only slices buses and ORs the per-lane collision pulses into the sticky flag.

Test Plan:
- Latency sweep: lane 0 grants tag 5 with lat 1, then tag 6 with lat 3, then tag 7 with lat 4 → rsrTag_o lane 0 is 5 in cycle t+1, 6 in t+4, 7 in t+6. Valid only in those cycles.
- Busy mask/merge: lane 1 grant tag 9 lat 4 at t → slotBusy_o for lane 1 bit L=3 is 1 at t+1, L=2 at t+2, L=1 at t+3. A lat-1 grant of tag 10 at t+1 broadcasts at t+2 with no conflict.
- Collision: tag 3 lat 3 at t, then tag 4 lat 2 at t+1 on the same lane → tag 3 broadcast at t+3, tag 4 never broadcast. collision_o is 1 from t+2 with the macro, 0 without.
- Flush: four tags in flight on lanes 0..3; flush_i with a simultaneous grant → rsrValid_o = 0000 for the next MAX_LATENCY+1 cycles.
- Reset mid-operation: pending tags plus sticky collision_o, assert reset 1 cycle → all outputs 0 next cycle. A new lat-2 grant after reset broadcasts normally.
- Illegal latency: grantLat_i = 0 and grantLat_i = 5 with MAX_LATENCY = 4 → no broadcast; collision_o set when the macro is enabled.
